// File: rtl/genesis_board_pkg.sv
// ---------------------------------------------------------------------------
// Module   : genesis_board_pkg
// Purpose  : Shared types and constants for the Genesis board top level.
//            Holds the ROM loader state encoding and the word indices used
//            by the optional header checksum verification.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

package genesis_board_pkg;

  // ROM loader transfer states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Word index of the checksum field in the cartridge header (byte 0x18E)
  localparam logic [21:0] HDR_CHECKSUM_WIDX   = 22'h0C7;
  // First word index covered by the checksum (byte 0x200)
  localparam logic [21:0] CHECKSUM_START_WIDX = 22'h100;

endpackage

`default_nettype wire

// File: rtl/rom_loader.sv
// ---------------------------------------------------------------------------
// Module   : rom_loader
// Purpose  : Streams a cartridge ROM image from parallel flash into the
//            core's ROM download port. Talks to the flash reader through a
//            toggle req/ack handshake (one 16-bit word per toggle) and honours
//            downstream backpressure on the download port.
// Config   : define ROM_LOADER_CHECKSUM_EN to verify the Genesis header
//            checksum; otherwise ochecksum_ok simply follows odone.
// Ports    : iclk/ireset        - clock, synchronous active-high reset
//            istart             - start pulse (ignored while busy / in delay)
//            ibase_addr/ilength - flash byte address of word 0, word count
//            ofl_addr/ofl_req   - flash request address and request toggle
//            ifl_ack/ifl_dout   - flash ack toggle and returned word
//            oioctl_*           - ROM download port (download, wr, addr, data)
//            iioctl_wait        - downstream stall
//            obusy/odone        - transfer in progress / sticky completion
//            ochecksum_ok       - header checksum result, valid with odone
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module rom_loader
  import genesis_board_pkg::*;
#(
  parameter int START_DELAY = 32
) (
  input  logic        iclk,
  input  logic        ireset,
  input  logic        istart,
  input  logic [22:0] ibase_addr,
  input  logic [21:0] ilength,
  output logic [22:0] ofl_addr,
  output logic        ofl_req,
  input  logic        ifl_ack,
  input  logic [15:0] ifl_dout,
  output logic        oioctl_download,
  output logic        oioctl_wr,
  output logic [23:0] oioctl_addr,
  output logic [15:0] oioctl_data,
  input  logic        iioctl_wait,
  output logic        obusy,
  output logic        odone,
  output logic        ochecksum_ok
);

  localparam int c_delay_w = (START_DELAY < 1) ? 1 : $clog2(START_DELAY + 1);
  localparam logic [c_delay_w-1:0] c_delay_init = START_DELAY[c_delay_w-1:0];
  localparam logic [c_delay_w-1:0] c_delay_one  = 1;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [c_delay_w-1:0] r_delay;
  logic [22:0]        r_base;
  logic [21:0]        r_len;
  logic [21:0]        r_idx;
  logic [22:0]        r_fl_addr;
  logic               r_fl_req;
  logic               r_download;
  logic               r_wr;
  logic [23:0]        r_io_addr;
  logic [15:0]        r_io_data;
  logic               r_busy;
  logic               r_done;

  logic               w_accept;
  logic               w_ack_match;
  logic               w_write_go;
  logic               w_last;

  assign w_accept    = (r_state == ST_IDLE) && istart && (r_delay == '0);
  // The reader answers a request by copying req into ack.
  assign w_ack_match = (ifl_ack == r_fl_req);
  assign w_write_go  = (r_state == ST_WRITE) && !iioctl_wait;
  assign w_last      = (r_idx == (r_len - 22'd1));

  // State register
  always_ff @(posedge iclk) begin
    if (ireset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept) w_state_nxt = (ilength == 22'd0) ? ST_DONE : ST_REQ;
      ST_REQ:   w_state_nxt = ST_WAIT;
      ST_WAIT:  if (w_ack_match) w_state_nxt = ST_WRITE;
      ST_WRITE: if (w_write_go) w_state_nxt = w_last ? ST_DONE : ST_REQ;
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Datapath and registered outputs
  always_ff @(posedge iclk) begin
    if (ireset) begin
      r_delay    <= c_delay_init;
      r_base     <= '0;
      r_len      <= '0;
      r_idx      <= '0;
      r_fl_addr  <= '0;
      r_fl_req   <= 1'b0;
      r_download <= 1'b0;
      r_wr       <= 1'b0;
      r_io_addr  <= '0;
      r_io_data  <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_wr <= 1'b0;
      if (r_delay != '0) begin
        r_delay <= r_delay - c_delay_one;
      end
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_base     <= ibase_addr & 23'h7F_FFFE;
            r_len      <= ilength;
            r_idx      <= '0;
            r_busy     <= 1'b1;
            r_done     <= 1'b0;
            r_download <= 1'b1;
          end
        end
        ST_REQ: begin
          // 23-bit sum: wraps silently at the top of the 8 MB flash
          r_fl_addr <= r_base + {r_idx, 1'b0};
          r_fl_req  <= ~r_fl_req;
        end
        ST_WAIT: begin
          if (w_ack_match) begin
            // Flash holds the even byte in [7:0]; ROM words are big-endian.
            r_io_data <= {ifl_dout[7:0], ifl_dout[15:8]};
            r_io_addr <= {1'b0, r_idx, 1'b0};
          end
        end
        ST_WRITE: begin
          if (!iioctl_wait) begin
            r_wr <= 1'b1;
            if (!w_last) begin
              r_idx <= r_idx + 22'd1;
            end
          end
        end
        ST_DONE: begin
          r_download <= 1'b0;
          r_busy     <= 1'b0;
          r_done     <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef ROM_LOADER_CHECKSUM_EN
  logic [15:0] r_sum;
  logic [15:0] r_hdr;
  logic        r_hdr_seen;
  logic        r_ck_ok;

  always_ff @(posedge iclk) begin
    if (ireset) begin
      r_sum      <= '0;
      r_hdr      <= '0;
      r_hdr_seen <= 1'b0;
      r_ck_ok    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_sum      <= '0;
        r_hdr      <= '0;
        r_hdr_seen <= 1'b0;
        r_ck_ok    <= 1'b0;
      end
      if (w_write_go) begin
        if (r_idx >= CHECKSUM_START_WIDX) begin
          r_sum <= r_sum + r_io_data;
        end
        if (r_idx == HDR_CHECKSUM_WIDX) begin
          r_hdr      <= r_io_data;
          r_hdr_seen <= 1'b1;
        end
      end
      // A short image never loads the header word, so it can never match.
      if (r_state == ST_DONE) begin
        r_ck_ok <= r_hdr_seen && (r_sum == r_hdr);
      end
    end
  end

  assign ochecksum_ok = r_ck_ok;
`else
  assign ochecksum_ok = r_done;
`endif

  assign ofl_addr        = r_fl_addr;
  assign ofl_req         = r_fl_req;
  assign oioctl_download = r_download;
  assign oioctl_wr       = r_wr;
  assign oioctl_addr     = r_io_addr;
  assign oioctl_data     = r_io_data;
  assign obusy           = r_busy;
  assign odone           = r_done;

endmodule

`default_nettype wire

// File: tb/tb_rom_loader.sv
// ---------------------------------------------------------------------------
// Module   : tb_rom_loader
// Purpose  : Self-checking bench for rom_loader. A flash reader model answers
//            the toggle handshake with random latency, a stall driver applies
//            random and directed backpressure, and a reference model computes
//            the expected flash addresses, download writes and checksum
//            result into queues that independent monitors pop and compare.
// Config   : honours ROM_LOADER_CHECKSUM_EN for the expected checksum result.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_rom_loader;

  localparam int START_DELAY = 32;

  logic        iclk = 1'b0;
  logic        ireset = 1'b1;
  logic        istart = 1'b0;
  logic [22:0] ibase_addr = '0;
  logic [21:0] ilength = '0;
  logic        ifl_ack = 1'b0;
  logic [15:0] ifl_dout = '0;
  logic        iioctl_wait = 1'b0;
  logic [22:0] ofl_addr;
  logic        ofl_req;
  logic        oioctl_download;
  logic        oioctl_wr;
  logic [23:0] oioctl_addr;
  logic [15:0] oioctl_data;
  logic        obusy;
  logic        odone;
  logic        ochecksum_ok;

  rom_loader #(.START_DELAY(START_DELAY)) dut (
    .iclk(iclk), .ireset(ireset), .istart(istart),
    .ibase_addr(ibase_addr), .ilength(ilength),
    .ofl_addr(ofl_addr), .ofl_req(ofl_req),
    .ifl_ack(ifl_ack), .ifl_dout(ifl_dout),
    .oioctl_download(oioctl_download), .oioctl_wr(oioctl_wr),
    .oioctl_addr(oioctl_addr), .oioctl_data(oioctl_data),
    .iioctl_wait(iioctl_wait),
    .obusy(obusy), .odone(odone), .ochecksum_ok(ochecksum_ok)
  );

  always #5 iclk = ~iclk;

  int n_vec = 0;
  int n_bad = 0;
  int toggles = 0;     // request toggles seen since last reset
  int writes = 0;      // write strobes seen since last reset
  int done_cnt = 0;    // odone rising edges seen
  int hook_toggle = -1;
  int dir_stall = 0;
  bit rand_stall = 1'b0;

  logic [15:0] mem_ovr [int];
  logic [22:0] exp_fl_q [$];
  logic [39:0] exp_wr_q [$];
  logic        exp_ok_q [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Flash contents: a fixed address-derived pattern unless overridden.
  function automatic logic [15:0] flash_word(input logic [22:0] a);
    if (mem_ovr.exists(int'(a))) return mem_ovr[int'(a)];
    return a[15:0] ^ {a[22:15], 8'h5A};
  endfunction

  // Reference model: what a transfer of len words from base must produce.
  task automatic push_expect(input logic [22:0] base, input int len);
    logic [22:0] b;
    logic [22:0] a;
    logic [15:0] w;
    logic [15:0] d;
    logic [15:0] sum;
    logic [15:0] hdr;
    b   = base & 23'h7F_FFFE;
    sum = '0;
    hdr = '0;
    for (int i = 0; i < len; i++) begin
      a = b + 23'(2 * i);
      w = flash_word(a);
      d = {w[7:0], w[15:8]};
      exp_fl_q.push_back(a);
      exp_wr_q.push_back({24'(2 * i), d});
      if (i >= 256) sum = sum + d;
      if (i == 199) hdr = d;
    end
`ifdef ROM_LOADER_CHECKSUM_EN
    exp_ok_q.push_back((len > 199) && (sum == hdr));
`else
    exp_ok_q.push_back(1'b1);
`endif
  endtask

  task automatic pulse_start(input logic [22:0] base, input int len);
    @(negedge iclk);
    ibase_addr = base;
    ilength    = 22'(len);
    istart     = 1'b1;
    @(negedge iclk);
    istart     = 1'b0;
  endtask

  task automatic start_xfer(input logic [22:0] base, input int len);
    push_expect(base, len);
    pulse_start(base, len);
  endtask

  task automatic wait_done(input int budget);
    int start;
    start = done_cnt;
    for (int i = 0; i < budget; i++) begin
      @(negedge iclk);
      if (done_cnt != start) return;
    end
    n_vec++;
    n_bad++;
    $display("FAIL done_timeout: odone not seen within %0d cycles", budget);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_fl_addr"}, 64'(ofl_addr), 0);
    check({tag, "_fl_req"}, 64'(ofl_req), 0);
    check({tag, "_download"}, 64'(oioctl_download), 0);
    check({tag, "_wr"}, 64'(oioctl_wr), 0);
    check({tag, "_io_addr"}, 64'(oioctl_addr), 0);
    check({tag, "_io_data"}, 64'(oioctl_data), 0);
    check({tag, "_busy"}, 64'(obusy), 0);
    check({tag, "_done"}, 64'(odone), 0);
    check({tag, "_ck_ok"}, 64'(ochecksum_ok), 0);
  endtask

  // Flash reader model: ack follows req after a random latency.
  initial begin : flash_model
    logic        last_req;
    logic [22:0] pend_addr;
    int          cnt;
    last_req  = 1'b0;
    pend_addr = '0;
    cnt       = -1;
    forever begin
      @(negedge iclk);
      if (ireset) begin
        ifl_ack  = 1'b0;
        last_req = 1'b0;
        cnt      = -1;
        toggles  = 0;
      end else begin
        if (cnt == 0) begin
          ifl_dout = flash_word(pend_addr);
          ifl_ack  = last_req;
          cnt      = -1;
        end else if (cnt > 0) begin
          cnt--;
        end
        if (ofl_req !== last_req) begin
          last_req  = ofl_req;
          pend_addr = ofl_addr;
          toggles++;
          if (exp_fl_q.size() == 0) check("fl_unexpected_req", 1, 0);
          else check("fl_addr", 64'(ofl_addr), 64'(exp_fl_q.pop_front()));
          cnt = $urandom_range(1, 12);
          if (toggles == hook_toggle) dir_stall = cnt + 12;
        end
      end
    end
  end

  // Backpressure driver, changes just after the active edge.
  initial begin : stall_drv
    forever begin
      @(posedge iclk);
      #1;
      if (dir_stall > 0) begin
        iioctl_wait = 1'b1;
        dir_stall--;
      end else begin
        iioctl_wait = rand_stall && ($urandom_range(0, 3) == 0);
      end
    end
  end

  // Download-port monitor and completion scoreboard.
  initial begin : monitor
    logic [23:0] prev_addr;
    logic [15:0] prev_data;
    logic        prev_wait;
    logic        prev_done;
    logic [39:0] e;
    prev_addr = '0;
    prev_data = '0;
    prev_wait = 1'b0;
    prev_done = 1'b0;
    forever begin
      @(negedge iclk);
      if (ireset) begin
        writes    = 0;
        prev_done = 1'b0;
        prev_wait = 1'b0;
      end else begin
        if (prev_wait) check("wr_while_wait", 64'(oioctl_wr), 0);
        if (oioctl_wr) begin
          writes++;
          if (exp_wr_q.size() == 0) begin
            check("wr_unexpected", 1, 0);
          end else begin
            e = exp_wr_q.pop_front();
            check("wr_addr", 64'(oioctl_addr), 64'(e[39:16]));
            check("wr_data", 64'(oioctl_data), 64'(e[15:0]));
          end
          check("wr_stable", 64'({prev_addr, prev_data}), 64'({oioctl_addr, oioctl_data}));
          check("req_vs_wr", 64'(toggles), 64'(writes));
        end
        if (odone && !prev_done) begin
          done_cnt++;
          if (exp_ok_q.size() == 0) check("done_unexpected", 1, 0);
          else check("checksum_ok", 64'(ochecksum_ok), 64'(exp_ok_q.pop_front()));
          check("done_words_left", 64'(exp_wr_q.size()), 0);
          check("done_busy", 64'(obusy), 0);
          check("done_download", 64'(oioctl_download), 0);
        end
        prev_done = odone;
        prev_wait = iioctl_wait;
        prev_addr = oioctl_addr;
        prev_data = oioctl_data;
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin : main
    int t0;
    logic [22:0] base;

    // Reset values
    ireset = 1'b1;
    repeat (3) @(negedge iclk);
    check_reset_outputs("reset");
    ireset = 1'b0;

    // Start inside the delay window is ignored
    repeat (4) @(negedge iclk);
    pulse_start(23'h000100, 2);
    repeat (3) begin
      @(negedge iclk);
      check("early_start_busy", 64'(obusy), 0);
    end
    check("early_start_no_req", 64'(toggles), 0);
    repeat (30) @(negedge iclk);

    // Basic load with a long stall during word 1
    for (int i = 0; i < 4; i++) mem_ovr[32'h100 + 2 * i] = 16'h3412;
    hook_toggle = toggles + 2;
    start_xfer(23'h000100, 4);
    @(negedge iclk);
    check("download_rise", 64'(oioctl_download), 1);
    wait_done(2000);
    check("basic_done", 64'(odone), 1);
    hook_toggle = -1;
    mem_ovr.delete();

    // Zero length: done two cycles after the start pulse, no request
    t0 = toggles;
    start_xfer(23'h001234, 0);
    @(negedge iclk);
    check("zero_done_timing", 64'(odone), 1);
    check("zero_no_req", 64'(toggles), 64'(t0));
    repeat (2) @(negedge iclk);

    // Flash address wrap at 8 MB, odd base
    start_xfer(23'h7F_FFFD, 4);
    wait_done(2000);

    // Random transfers with random backpressure; a start while busy is ignored
    rand_stall = 1'b1;
    for (int n = 0; n < 8; n++) begin
      base = 23'($urandom);
      start_xfer(base, $urandom_range(0, 9));
      if (n == 3) begin
        repeat (6) @(negedge iclk);
        pulse_start(23'h000000, 3);
      end
      wait_done(4000);
    end

    // Header checksum: match then mismatch
    mem_ovr[32'h040000 + 2 * 32'hC7]  = 16'h0300;
    mem_ovr[32'h040000 + 2 * 32'h100] = 16'h0100;
    mem_ovr[32'h040000 + 2 * 32'h101] = 16'h0200;
    start_xfer(23'h040000, 32'h102);
    wait_done(20000);
    mem_ovr[32'h040000 + 2 * 32'hC7]  = 16'h0400;
    start_xfer(23'h040000, 32'h102);
    wait_done(20000);
    mem_ovr.delete();
    rand_stall = 1'b0;

    // Reset while waiting for word 2
    t0 = toggles;
    start_xfer(23'h002000, 6);
    for (int i = 0; i < 500 && toggles < t0 + 3; i++) @(negedge iclk);
    check("midreset_reached_word2", 64'(toggles), 64'(t0 + 3));
    @(negedge iclk);
    ireset = 1'b1;
    @(negedge iclk);
    check_reset_outputs("midreset");
    exp_fl_q.delete();
    exp_wr_q.delete();
    exp_ok_q.delete();
    @(negedge iclk);
    ireset = 1'b0;
    repeat (START_DELAY + 4) @(negedge iclk);
    start_xfer(23'h002000, 6);
    wait_done(2000);

    repeat (5) @(negedge iclk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/rom_loader.md
# rom_loader

Requester-side client of the board flash reader's toggle req/ack interface. On a start pulse it streams a cartridge ROM image of `ilength` 16-bit words from parallel flash into the core's ROM download port, one word per handshake, with downstream backpressure. It sits between the flash reader and the SDRAM/ROM download path in the board top level. It can optionally verify the Genesis header checksum.

## Interface
Parameters:
- `START_DELAY`, default 32: cycles after reset release before `istart` is accepted. Covers the flash reader's reset/init window, during which it copies req into ack and would lose a toggle.

Ports:
- `iclk` in 1: clock, 54 MHz.
- `ireset` in 1: reset, synchronous, active-high. Clock is `iclk`.
- `istart` in 1: one-cycle start pulse; ignored while busy or inside `START_DELAY`.
- `ibase_addr` in 23: flash byte address of ROM word 0; bit 0 is ignored (forced even).
- `ilength` in 22: number of 16-bit words to load.
- `ofl_addr` out 23: flash byte address for the current request.
- `ofl_req` out 1: request toggle.
- `ifl_ack` in 1: ack toggle from the flash reader.
- `ifl_dout` in 16: flash word; `[7:0]` is the even byte, `[15:8]` is the odd byte.
- `oioctl_download` out 1: high for the whole transfer.
- `oioctl_wr` out 1: one-cycle write strobe.
- `oioctl_addr` out 24: destination byte address (word index × 2).
- `oioctl_data` out 16: big-endian ROM word.
- `iioctl_wait` in 1: downstream stall; no write is issued while it is high.
- `obusy` out 1: transfer in progress.
- `odone` out 1: sticky completion flag, cleared by the next accepted start.
- `ochecksum_ok` out 1: header checksum match, valid while `odone` is high.

## Operation
- Reset values:
  - `ofl_addr` = 0, `ofl_req` = 0.
  - `oioctl_download`, `oioctl_wr`, `obusy`, `odone`, `ochecksum_ok` = 0.
  - `oioctl_addr` = 0, `oioctl_data` = 0.
  - State IDLE; delay counter = `START_DELAY`.
- State machine:
  - **IDLE**: accept `istart` when the delay counter is 0. Then:
    - latch base (bit 0 cleared) and length;
    - clear the word index and checksum;
    - set `obusy`, clear `odone`, set `oioctl_download`.
    - If length = 0, go to DONE; otherwise go to REQ.
  - **REQ**: in one cycle, `ofl_addr` <= base + 2×index and `ofl_req` <= ~`ofl_req`. Go to WAIT.
  - **WAIT**: when `ifl_ack == ofl_req`:
    - capture `oioctl_data` <= {`ifl_dout[7:0]`, `ifl_dout[15:8]`};
    - `oioctl_addr` <= {index, 1'b0};
    - go to WRITE.
  - **WRITE**: if `iioctl_wait` = 0, pulse `oioctl_wr` for one cycle and update the checksum. Then:
    - if index = length−1, go to DONE;
    - otherwise index++ and go to REQ.
    - If `iioctl_wait` = 1, stay in WRITE with data and address held.
  - **DONE**: deassert `oioctl_download` and `obusy`; set `odone`; go to IDLE.
- Arithmetic:
  - index is 22 bits.
  - Flash address is base + {index, 1'b0}, truncated to 23 bits; it wraps silently at 8 MB.
- `istart` while busy: ignored, no effect on the transfer.
- `ireset` mid-transfer:
  - all outputs return to reset values immediately; the transfer is abandoned.
  - The flash reader shares `ireset`, so the toggle pair re-aligns through its reset state.
- `ifl_ack` toggling while not in WAIT: ignored. By protocol this never happens.

## Timing
- Request issue: 1 cycle (REQ), then the flash reader's latency (~15 cycles at 54 MHz), then 1 cycle capture, then ≥1 cycle WRITE.
- Without stalls, per-word period = 3 cycles + flash latency.
- `oioctl_wr` is high for exactly one cycle per word. Data and address are stable from the cycle before the strobe through the strobe.
- `oioctl_download` rises the cycle after an accepted `istart`. It falls in the DONE cycle, which is the cycle after the last `oioctl_wr`.
- `odone` and `ochecksum_ok` update in the same cycle.

## Configuration
- `ROM_LOADER_CHECKSUM_EN` defined:
  - 16-bit modulo sum of every written word with word index ≥ 0x100 (byte 0x200 onward);
  - capture the word at index 0xC7 (byte 0x18E) as the header value;
  - in DONE, `ochecksum_ok` <= (sum == header).
  - If length ≤ 0xC7, the header word is never loaded and `ochecksum_ok` = 0.
- Macro undefined: no adder or header register; `ochecksum_ok` is held at 1'b1 whenever `odone` is 1, and 0 otherwise.

## Structure
- Shared package `genesis_board_pkg` holds:
  - the state enum;
  - `HDR_CHECKSUM_WIDX` = 22'h0C7;
  - `CHECKSUM_START_WIDX` = 22'h100.
- Single module, no sub-modules. The toggle-handshake compare is one inline expression, not worth a sub-module.

## Test plan
- **Start inside delay window**: reset, then `istart` at cycle 5 → ignored, `obusy` stays 0. `istart` at cycle 40 → accepted.
- **Basic load**: base 0x000100, length 4, flash model returns word 0x3412 at each even address → four `oioctl_wr` strobes with addr 0, 2, 4, 6 and data 0x1234 each. `ofl_addr` sequence 0x100, 0x102, 0x104, 0x106. `odone` = 1.
- **Backpressure**: hold `iioctl_wait` high for 10 cycles during word 1 → the strobe is delayed, data and address stay stable, and no new `ofl_req` toggle happens until the write completes.
- **Zero length**: `istart` with length 0 → no `ofl_req` toggle, `odone` = 1 two cycles later, `ochecksum_ok` = 0 with the macro defined.
- **Checksum**: length 0x102, header word 0x0003, words 0x100 = 0x0001 and 0x101 = 0x0002 → `ochecksum_ok` = 1. With header 0x0004 → `ochecksum_ok` = 0.
- **Reset mid-transfer**: `ireset` during WAIT at word 2 → next cycle all outputs are at reset values. A subsequent `istart` after `START_DELAY` reloads from word 0 correctly.
